// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: four-state multi-cycle RV32I ALU-subset core
// with a loadable instruction memory and a 32-entry register file.
module rv_multicycle_core #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoadEn,
  input  logic [AW-1:0]    iLoadAddr,
  input  logic [31:0]      iLoadData,
  input  logic             iStart,
  output logic [WIDTH-1:0] oRd,
  output logic [4:0]       oRdAddr,
  output logic             oRdValid,
  output logic [AW-1:0]    oPc,
  output logic             oBusy,
  output logic             oHalted,
  output logic             oIllegal,
  output logic [31:0]      oRetired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    pc_q;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [WIDTH-1:0] rd_q;
  logic [4:0]       rd_addr_q;
  logic             rd_vld_q;
  logic             ill_q;
  logic [31:0]      ret_q;
  logic [WIDTH-1:0] rf_q [32];
  logic [31:0]      imem_q [DEPTH];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic       is_i, is_ecall, legal, stop;
  logic       idle_like;

  assign opc      = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign f3       = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign f7       = ir_q[31:25];
  assign is_i     = (opc == 7'b0010011);
  assign is_ecall = (ir_q == 32'h0000_0073);
  assign stop     = is_ecall || !legal;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

  // IR[25] is shamt[5] on 64-bit datapaths, otherwise it must be zero
  always_comb begin
    legal = 1'b0;
    if (opc == 7'b0110011) begin
      legal = (f7 == 7'h00) ||
              (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
    end else if (is_i) begin
      unique case (f3)
        3'b001:  legal = (ir_q[31:26] == 6'h00) &&
                         !(WIDTH == 32 && ir_q[25]);
        3'b101:  legal = (ir_q[31:26] == 6'h00 ||
                          ir_q[31:26] == 6'h10) &&
                         !(WIDTH == 32 && ir_q[25]);
        default: legal = 1'b1;
      endcase
    end
  end

  logic [WIDTH-1:0] imm, opb, alu, sra;
  logic [SW-1:0]    sh;

  assign imm = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
  assign opb = is_i ? imm : b_q;
  assign sh  = opb[SW-1:0];
  assign sra = $signed(a_q) >>> sh;

  always_comb begin
    unique case (f3)
      3'b000:  alu = (!is_i && ir_q[30]) ? a_q - opb : a_q + opb;
      3'b001:  alu = a_q << sh;
      3'b010:  alu = {{(WIDTH-1){1'b0}},
                      $signed(a_q) < $signed(opb)};
      3'b011:  alu = {{(WIDTH-1){1'b0}}, a_q < opb};
      3'b100:  alu = a_q ^ opb;
      3'b101:  alu = ir_q[30] ? sra : a_q >> sh;
      3'b110:  alu = a_q | opb;
      default: alu = a_q & opb;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (iStart) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = stop ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iLoadEn && idle_like) imem_q[iLoadAddr] <= iLoadData;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      ill_q     <= 1'b0;
      ret_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (iStart) begin
            pc_q  <= '0;
            ret_q <= '0;
            ill_q <= 1'b0;
          end
        end
        S_FETCH: ir_q <= imem_q[pc_q];
        S_DECODE: begin
          a_q <= rf_q[rs1];
          b_q <= rf_q[rs2];
          if (!is_ecall && !legal) ill_q <= 1'b1;
        end
        S_EXEC: y_q <= alu;
        S_WB: begin
          if (rd != 5'd0) rf_q[rd] <= y_q;
          rd_q      <= y_q;
          rd_addr_q <= rd;
          rd_vld_q  <= 1'b1;
          ret_q     <= ret_q + 32'd1;
          pc_q      <= pc_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign oRd      = rd_q;
  assign oRdAddr  = rd_addr_q;
  assign oRdValid = rd_vld_q;
  assign oPc      = pc_q;
  assign oBusy    = !idle_like;
  assign oHalted  = (state_q == S_HALT);
  assign oIllegal = ill_q;
  assign oRetired = ret_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: scoreboard bench for rv_multicycle_core,
// 32-bit/64-word and 64-bit/4-word instances.
module tb_rv_multicycle_core;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } sb_t;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance
  logic        rst = 1'b1, ld = 1'b0, st = 1'b0;
  logic [5:0]  la = '0;
  logic [31:0] ldd = '0;
  logic [31:0] rd;
  logic [4:0]  rda;
  logic        vld, busy, halted, ill;
  logic [5:0]  pc;
  logic [31:0] ret;

  rv_multicycle_core #(.WIDTH(32), .DEPTH(64)) u_dut (
    .iClk(clk), .iRst(rst), .iLoadEn(ld),
    .iLoadAddr(la), .iLoadData(ldd), .iStart(st),
    .oRd(rd), .oRdAddr(rda), .oRdValid(vld),
    .oPc(pc), .oBusy(busy), .oHalted(halted),
    .oIllegal(ill), .oRetired(ret)
  );

  // 64-bit instance, 4-word memory
  logic        rst6 = 1'b1, ld6 = 1'b0, st6 = 1'b0;
  logic [1:0]  la6 = '0;
  logic [31:0] ldd6 = '0;
  logic [63:0] rd6;
  logic [4:0]  rda6;
  logic        vld6, busy6, halt6, ill6;
  logic [1:0]  pc6;
  logic [31:0] ret6;

  rv_multicycle_core #(.WIDTH(64), .DEPTH(4)) u_dut64 (
    .iClk(clk), .iRst(rst6), .iLoadEn(ld6),
    .iLoadAddr(la6), .iLoadData(ldd6), .iStart(st6),
    .oRd(rd6), .oRdAddr(rda6), .oRdValid(vld6),
    .oPc(pc6), .oBusy(busy6), .oHalted(halt6),
    .oIllegal(ill6), .oRetired(ret6)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ii(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rdx);
    return {imm, rs1, f3, rdx, 7'b0010011};
  endfunction

  function automatic logic [31:0] rr(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rdx);
    return {f7, rs2, rs1, f3, rdx, 7'b0110011};
  endfunction

  sb_t q32[$];
  sb_t q64[$];
  int  last32 = 0, last64 = 0, n64 = 0;
  bit  hl32 = 0, hl64 = 0;

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    q32.push_back('{a: a, d: d});
  endtask

  task automatic push6(input logic [4:0] a, input logic [63:0] d);
    q64.push_back('{a: a, d: d});
  endtask

  always @(negedge clk) begin
    if (!rst && vld) begin
      if (q32.size() == 0) begin
        check("extra_vld", vld, 1'b0);
      end else begin
        check("rd_addr", rda, q32[0].a);
        check("rd_data", rd, q32[0].d);
        void'(q32.pop_front());
      end
      if (hl32) check("spacing", cyc - last32, 4);
      last32 <= cyc;
      hl32   <= 1'b1;
    end else if (halted || rst) begin
      hl32 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst6 && vld6) begin
      if (q64.size() == 0) begin
        check("extra_vld6", vld6, 1'b0);
      end else begin
        check("rd_addr6", rda6, q64[0].a);
        check("rd_data6", rd6, q64[0].d);
        void'(q64.pop_front());
      end
      if (hl64) check("spacing6", cyc - last64, 4);
      last64 <= cyc;
      hl64   <= 1'b1;
      n64    <= n64 + 1;
    end else if (halt6 || rst6) begin
      hl64 <= 1'b0;
    end
  end

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld = 1'b1; la = a; ldd = d;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic start();
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
  endtask

  task automatic load_start(input logic [5:0] a,
                            input logic [31:0] d);
    ld = 1'b1; la = a; ldd = d; st = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0; st = 1'b0;
  endtask

  task automatic wait_halt();
    int i = 0;
    while (!halted && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    check("halt_tmo", halted, 1'b1);
    check("not_busy", busy, 1'b0);
  endtask

  task automatic run_halt(input logic [31:0] instr,
                          input logic exp_ill);
    load_start(6'd0, instr);
    check("h_fetch_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("h_dec_halt", halted, 1'b0);
    @(posedge clk); #1;
    check("h_halt", halted, 1'b1);
    check("h_busy", busy, 1'b0);
    check("h_ill", ill, exp_ill);
    check("h_pc", pc, 6'd0);
    check("h_ret", ret, 32'd0);
  endtask

  task automatic load6(input logic [1:0] a, input logic [31:0] d);
    ld6 = 1'b1; la6 = a; ldd6 = d;
    @(posedge clk); #1;
    ld6 = 1'b0;
  endtask

  task automatic start6();
    st6 = 1'b1;
    @(posedge clk); #1;
    st6 = 1'b0;
  endtask

  task automatic wait_n64(input int k);
    int i = 0;
    while (n64 < k && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check("n64_tmo", n64 >= k, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_halt", halted, 1'b0);
    check("rst_ret", ret, 32'd0);
    check("rst_rd", {rda, rd}, '0);

    // reset in EXECUTE abandons ADDI x1,x0,5
    load(6'd0, ii(12'd5, 5'd0, 3'd0, 5'd1));
    load(6'd1, ECALL);
    start();
    repeat (2) begin @(posedge clk); #1; end
    check("exec_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_pc", pc, 6'd0);
    check("mid_vld", vld, 1'b0);
    check("mid_rd", {rda, rd}, '0);
    check("mid_ret", ret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    load(6'd0, rr(7'h00, 5'd0, 5'd1, 3'd0, 5'd7));
    push(5'd7, 64'd0);
    start();
    wait_halt();
    check("x1_ret", ret, 32'd1);
    check("x1_pc", pc, 6'd1);

    // ALU program
    load(6'd0, ii(12'd7, 5'd0, 3'd0, 5'd1));
    load(6'd1, ii(12'hFFD, 5'd0, 3'd0, 5'd2));
    load(6'd2, rr(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    load(6'd3, rr(7'h20, 5'd1, 5'd2, 3'd0, 5'd4));
    load(6'd4, rr(7'h00, 5'd2, 5'd1, 3'd3, 5'd5));
    load(6'd5, ECALL);
    push(5'd1, 64'h7);
    push(5'd2, 64'hFFFF_FFFD);
    push(5'd3, 64'h4);
    push(5'd4, 64'hFFFF_FFF6);
    push(5'd5, 64'h1);
    start();
    wait_halt();
    check("alu_ill", ill, 1'b0);
    check("alu_ret", ret, 32'd5);
    check("alu_pc", pc, 6'd5);

    // shifts and logic on preserved x1=7, x2=-3
    load(6'd0, ii(12'h401, 5'd2, 3'd5, 5'd6));
    load(6'd1, ii(12'h001, 5'd2, 3'd5, 5'd8));
    load(6'd2, ii(12'h004, 5'd2, 3'd1, 5'd9));
    load(6'd3, rr(7'h00, 5'd1, 5'd2, 3'd2, 5'd10));
    load(6'd4, ii(12'hFFF, 5'd1, 3'd4, 5'd11));
    load(6'd5, ii(12'h030, 5'd1, 3'd6, 5'd12));
    load(6'd6, rr(7'h00, 5'd2, 5'd1, 3'd7, 5'd13));
    load(6'd7, rr(7'h00, 5'd1, 5'd1, 3'd1, 5'd14));
    load(6'd8, ECALL);
    push(5'd6, 64'hFFFF_FFFE);
    push(5'd8, 64'h7FFF_FFFE);
    push(5'd9, 64'hFFFF_FFD0);
    push(5'd10, 64'h1);
    push(5'd11, 64'hFFFF_FFF8);
    push(5'd12, 64'h37);
    push(5'd13, 64'h5);
    push(5'd14, 64'h380);
    start();
    wait_halt();
    check("sh_ret", ret, 32'd8);

    // x0 writes and back-to-back dependencies
    load(6'd0, ii(12'd9, 5'd0, 3'd0, 5'd0));
    load(6'd1, rr(7'h00, 5'd0, 5'd0, 3'd0, 5'd7));
    load(6'd2, ii(12'd0, 5'd0, 3'd0, 5'd1));
    for (int i = 3; i < 6; i++)
      load(6'(i), ii(12'd1, 5'd1, 3'd0, 5'd1));
    load(6'd6, ECALL);
    push(5'd0, 64'd9);
    push(5'd7, 64'd0);
    push(5'd1, 64'd0);
    push(5'd1, 64'd1);
    push(5'd1, 64'd2);
    push(5'd1, 64'd3);
    start();
    wait_halt();
    check("dep_ret", ret, 32'd6);

    // illegal at address 2; load while busy is ignored
    load(6'd0, ii(12'd1, 5'd1, 3'd0, 5'd1));
    load(6'd1, ii(12'd1, 5'd1, 3'd0, 5'd1));
    load(6'd2, 32'h0000_2083);
    push(5'd1, 64'd4);
    push(5'd1, 64'd5);
    start();
    load(6'd2, ECALL);
    wait_halt();
    check("ill_flag", ill, 1'b1);
    check("ill_pc", pc, 6'd2);
    check("ill_ret", ret, 32'd2);
    load(6'd2, rr(7'h00, 5'd0, 5'd1, 3'd0, 5'd14));
    load(6'd3, ECALL);
    push(5'd1, 64'd6);
    push(5'd1, 64'd7);
    push(5'd14, 64'd7);
    start();
    wait_halt();
    check("re_ill", ill, 1'b0);
    check("re_ret", ret, 32'd3);
    check("re_pc", pc, 6'd3);

    // halt timing, load+start in one cycle, illegal encodings
    run_halt(rr(7'h20, 5'd2, 5'd1, 3'd1, 5'd3), 1'b1);
    run_halt(rr(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1);
    run_halt(ii(12'h020, 5'd1, 3'd1, 5'd3), 1'b1);
    run_halt(ii(12'h201, 5'd1, 3'd5, 5'd3), 1'b1);
    run_halt(32'h0000_0067, 1'b1);
    run_halt(ECALL, 1'b0);

    // 64-bit: PC wrap with DEPTH=4
    #1 rst6 = 1'b0;
    for (int i = 0; i < 4; i++)
      load6(2'(i), ii(12'd1, 5'd1, 3'd0, 5'd1));
    for (int i = 1; i <= 5; i++) push6(5'd1, 64'(i));
    start6();
    wait_n64(4);
    check("wrap_pc", pc6, 2'd0);
    check("wrap_ret", ret6, 32'd4);
    wait_n64(5);
    rst6 = 1'b1;
    #1;
    check("r6_ret", ret6, 32'd0);
    check("r6_busy", busy6, 1'b0);
    @(posedge clk); #1;
    rst6 = 1'b0;

    // 64-bit shifts with shamt 33
    load6(2'd0, ii(12'hFFD, 5'd0, 3'd0, 5'd2));
    load6(2'd1, ii(12'h421, 5'd2, 3'd5, 5'd6));
    load6(2'd2, ii(12'h021, 5'd2, 3'd5, 5'd8));
    load6(2'd3, ECALL);
    push6(5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    push6(5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    push6(5'd8, 64'h0000_0000_7FFF_FFFF);
    start6();
    for (int i = 0; i < 100 && !halt6; i++) begin
      @(posedge clk); #1;
    end
    check("h64", halt6, 1'b1);
    check("h64_ill", ill6, 1'b0);
    check("h64_ret", ret6, 32'd3);
    check("h64_pc", pc6, 2'd3);

    repeat (3) @(posedge clk);
    #1;
    check("q32_left", q32.size(), 0);
    check("q64_left", q64.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
